sram_arbiter: RTL

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/sram_arbiter.sv
// Two-requester arbiter in front of a single-port SRAM controller.
// Round-robin on ties, one transaction in flight, sticky watchdog.
module sram_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        aRead,
  input  logic        aWrite,
  input  logic [31:0] aAddress,
  input  logic [31:0] aDataIn,
  output logic [31:0] aDataOut,
  output logic        aFreeze,
  input  logic        bRead,
  input  logic        bWrite,
  input  logic [31:0] bAddress,
  input  logic [31:0] bDataIn,
  output logic [31:0] bDataOut,
  output logic        bFreeze,
  output logic        memRead,
  output logic        memWrite,
  output logic [31:0] memAddress,
  output logic [31:0] memDataIn,
  input  logic [31:0] memDataOut,
  input  logic        memFreeze,
  output logic [1:0]  grant,
  output logic        memTimeout
);

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, RESP
  } state_t;

  state_t      state_q, state_d;
  logic        req_a, req_b;
  logic        take, pick_b;
  logic        hit, done, active;
  logic        owner_q, op_q, last_q;
  logic [31:0] addr_q, data_q;
  logic [3:0]  wdog_q;

  assign req_a = aRead | aWrite;
  assign req_b = bRead | bWrite;

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    pick_b  = 1'b0;
    hit     = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_a | req_b) begin
          take    = 1'b1;
          pick_b  = req_b & (~req_a | ~last_q);
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        // wdog_q is 0 only in the first WAIT cycle
        if (wdog_q == 4'd14) begin
          hit     = 1'b1;
          state_d = RESP;
        end else if (wdog_q != 4'd0 && !memFreeze) begin
          done    = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      op_q       <= 1'b0;
      last_q     <= 1'b1;
      addr_q     <= '0;
      data_q     <= '0;
      wdog_q     <= '0;
      memTimeout <= 1'b0;
      aDataOut   <= '0;
      bDataOut   <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        owner_q <= pick_b;
        op_q    <= pick_b ? bWrite : aWrite;
        addr_q  <= pick_b ? bAddress : aAddress;
        data_q  <= pick_b ? bDataIn : aDataIn;
      end
      if (state_q == ISSUE)
        wdog_q <= '0;
      else if (state_q == WAIT)
        wdog_q <= wdog_q + 4'd1;
      if (hit)
        memTimeout <= 1'b1;
      if (state_q == RESP)
        last_q <= owner_q;
      if (done && !op_q) begin
        if (owner_q)
          bDataOut <= memDataOut;
        else
          aDataOut <= memDataOut;
      end
    end
  end

  assign active = ~rst & (state_q != IDLE);

  assign memRead  = ~rst & (state_q == ISSUE) & ~op_q;
  assign memWrite = ~rst & (state_q == ISSUE) & op_q;

  assign memAddress = active ? addr_q : '0;
  assign memDataIn  = active ? data_q : '0;

  assign grant = active ? {owner_q, ~owner_q} : 2'b00;

  assign aFreeze = req_a & ~((state_q == RESP) & ~owner_q);
  assign bFreeze = req_b & ~((state_q == RESP) & owner_q);

endmodule
